input_daemon_param: RTL and testbench
=====================================

# input_daemon_param

Parametrised ingress daemon for the switch fabric. It accepts one header-framed packet stream per instance over a valid/ready handshake and parses each header for destination and payload length. It then steers the header and its payload words into one of `NUM_PORTS` registered output-buffer slots, with per-port backpressure. It generalises the fixed 4-port, free-running input daemon with configurable port count and data width, flow control, bad-destination dropping and an optional broadcast mode.

## Interface
- `NUM_PORTS`, 4: number of output buffers; legal range 2..254.
- `DATA_W`, 32: word width; minimum 24.
- `LEN_W`, derived as `DATA_W-16`: payload-length field width (localparam).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `input_word` is valid.
- `input_word`  in  `DATA_W`  header or payload word.
- `in_ready`  out  1  word is accepted on an edge where `in_valid && in_ready`.
- `out_ready`  in  `NUM_PORTS`  bit p-1 means output buffer p can take a word.
- `to_output_buf`  out  `NUM_PORTS*(DATA_W+1)`
  - Port p (1-based) occupies slice `[p*(DATA_W+1)-1 -: DATA_W+1]`.
  - Slice MSB is valid; the low `DATA_W` bits are data.
- `pkt_done`  out  1  one-cycle pulse when the last word of a forwarded packet is accepted.
- `drop_err`  out  1  one-cycle pulse when a header with an illegal destination is accepted.

## Operation
- Header layout:
  - `[DATA_W-1:DATA_W-8]` is the tag and is carried through, not interpreted.
  - `[DATA_W-9:8]` is the payload length L (`LEN_W` bits).
  - `[7:0]` is the destination D.
- Legal D is 1..`NUM_PORTS`. D=0xFF is broadcast when enabled (see Configuration). Any other D is illegal.
- The FSM has three states: IDLE, FWD, DROP.
  - IDLE: the next accepted word is a header.
    - Legal D: the header is forwarded to slot D. If L>0, latch D, set `remaining`=L and go to FWD. If L=0, pulse `pkt_done` and stay in IDLE.
    - Illegal D: pulse `drop_err`; nothing is forwarded. If L>0, set `remaining`=L and go to DROP. Otherwise stay in IDLE.
  - FWD: each accepted word goes to the latched slot and decrements `remaining`. Accepting the word while `remaining`=1 pulses `pkt_done` and returns to IDLE.
  - DROP: `in_ready`=1. Accepted words are discarded and decrement `remaining`. At `remaining`=1 the FSM returns to IDLE; `pkt_done` does not pulse.
- Output slot p:
  - A slot is free when valid=0 or `out_ready[p-1]`=1 that cycle.
  - A load sets valid=1 and overwrites data.
  - With no load, `valid && out_ready` clears valid.
  - Load and drain in the same cycle leaves valid=1 with the new data.
- `in_ready` is combinational:
  - IDLE: slot D is free if D is legal; 1 if D is illegal; all slots free for broadcast.
  - FWD: latched slot free.
  - DROP: 1.
- `in_ready` may depend on `input_word` and `out_ready`. It never depends combinationally on `in_valid`.
- Words that are not accepted have no effect. Upstream holds the word until it is accepted.
- `remaining` is `LEN_W` bits wide and never wraps: a packet of length 2^`LEN_W`-1 is handled exactly.

## Timing
- Reset values:
  - state=IDLE, `remaining`=0.
  - All slot valid bits 0, slot data 0; `to_output_buf`=0.
  - `pkt_done`=0, `drop_err`=0.
  - `in_ready` follows IDLE rules.
- Latency is 1 cycle: a word accepted at edge k is visible on its slot after edge k.
- Throughput is 1 word/cycle while the target `out_ready` stays high.
- `pkt_done` and `drop_err` are registered and are high for the cycle after the accepting edge.
- Reset mid-packet aborts the packet. Slot contents are lost, and the next accepted word is treated as a header.

## Configuration
- `INPUT_DAEMON_BROADCAST_EN`
  - Defined: D=0xFF is legal. The header and all payload words load every slot. `in_ready` requires all slots free. `pkt_done` pulses once per packet.
  - Undefined: D=0xFF is illegal and follows the drop path with `drop_err`.

## Test plan
- Reset, then header {tag 3, L=5, D=1} followed by words 32, 10, 7, 128, 200 with `out_ready`=all ones:
  - Port 1 shows the header and then the 5 words on consecutive cycles, each 1 cycle after acceptance.
  - Other ports stay valid=0.
  - `pkt_done` pulses once after word 200.
- Header {tag 2, L=3, D=2} followed by 119, 78, 43, with `out_ready[1]` low for 3 cycles after the header:
  - `in_ready` is 0 while slot 2 is full.
  - No word is lost or duplicated; the order is 119, 78, 43.
- Header D=9 (`NUM_PORTS`=4) with L=2, then 5, 6, then header {D=3, L=0}:
  - `drop_err` pulses once; no slot loads.
  - The L=0 header appears on port 3 with a `pkt_done` pulse.
- `NUM_PORTS`=8, `DATA_W`=48: header {D=8, L=1}, payload 0xABCDEF012345 appears on slice 8 intact.
- Assert `rst` after the 2nd payload word of an L=5 packet:
  - All outputs return to 0.
  - The next word is parsed as a header.
- With the macro defined, header D=0xFF L=1 and payload 77:
  - All 4 slots show 77.
  - With one `out_ready` low, `in_ready` stays 0 until that slot is free.
  - Without the macro, the same stimulus yields `drop_err`.

Source files
------------

// File: rtl/input_daemon_param.sv
// input_daemon_param: header-framed ingress daemon steering packets into NUM_PORTS
// registered output slots with valid/ready flow control and per-port backpressure.
// Optional broadcast (destination 0xFF) is enabled by defining INPUT_DAEMON_BROADCAST_EN.
module input_daemon_param #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [DATA_W-1:0]                 input_word,
    output logic                              in_ready,
    input  logic [NUM_PORTS-1:0]              out_ready,
    output logic [NUM_PORTS*(DATA_W+1)-1:0]   to_output_buf,
    output logic                              pkt_done,
    output logic                              drop_err
);

    localparam int unsigned LEN_W = DATA_W - 16;

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic [NUM_PORTS-1:0] tgt_q, tgt_d;          // slots fed by the current packet
    logic                 pkt_done_q, pkt_done_d;
    logic                 drop_err_q, drop_err_d;

    logic [NUM_PORTS-1:0] slot_valid_q;
    logic [DATA_W-1:0]    slot_data_q [NUM_PORTS];

    logic [7:0]           hdr_dst;
    logic [LEN_W-1:0]     hdr_len;
    logic [NUM_PORTS-1:0] hdr_mask;
    logic                 hdr_legal;
    logic [NUM_PORTS-1:0] slot_free;
    logic [NUM_PORTS-1:0] cur_mask;
    logic [NUM_PORTS-1:0] slot_load;
    logic                 accept;

    assign hdr_dst = input_word[7:0];
    assign hdr_len = input_word[DATA_W-9:8];

    // Header decode: destination to slot mask; an empty mask means illegal destination.
    always_comb begin
        hdr_mask = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            hdr_mask[p] = (hdr_dst == 8'(p + 1));
        end
`ifdef INPUT_DAEMON_BROADCAST_EN
        if (hdr_dst == 8'hFF) begin
            hdr_mask = '1;
        end
`endif
        hdr_legal = |hdr_mask;
    end

    // State register, length counter and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            tgt_q       <= '0;
            pkt_done_q  <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tgt_q       <= tgt_d;
            pkt_done_q  <= pkt_done_d;
            drop_err_q  <= drop_err_d;
        end
    end

    // Next-state logic: header parse in idle, payload countdown in forward/drop.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tgt_d       = tgt_q;
        pkt_done_d  = 1'b0;
        drop_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hdr_legal) begin
                        if (hdr_len == '0) begin
                            pkt_done_d = 1'b1;
                        end else begin
                            tgt_d       = hdr_mask;
                            remaining_d = hdr_len;
                            state_d     = StFwd;
                        end
                    end else begin
                        drop_err_d = 1'b1;
                        if (hdr_len != '0) begin
                            remaining_d = hdr_len;
                            state_d     = StDrop;
                        end
                    end
                end
            end
            StFwd: begin
                if (accept) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        pkt_done_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StDrop: begin
                if (accept) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: readiness needs every targeted slot free; drops target nothing.
    always_comb begin
        slot_free = ~slot_valid_q | out_ready;
        unique case (state_q)
            StIdle:  cur_mask = hdr_mask;
            StFwd:   cur_mask = tgt_q;
            default: cur_mask = '0;
        endcase
        in_ready  = &(slot_free | ~cur_mask);
        accept    = in_valid & in_ready;
        slot_load = accept ? cur_mask : '0;
    end

    // Output slots: a load wins over a drain so load+drain keeps valid with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                slot_data_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (slot_load[p]) begin
                    slot_valid_q[p] <= 1'b1;
                    slot_data_q[p]  <= input_word;
                end else if (out_ready[p]) begin
                    slot_valid_q[p] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_slot_out
        assign to_output_buf[(p+1)*(DATA_W+1)-1 -: DATA_W+1] = {slot_valid_q[p], slot_data_q[p]};
    end

    assign pkt_done = pkt_done_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_input_daemon_param.sv
// Testbench for input_daemon_param: directed and random packets checked against a
// packet-level reference model; a second 8-port 48-bit instance checks wide words.
module tb_input_daemon_param;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int SW = W + 1;
    localparam int BNP = 8;
    localparam int BW  = 48;
    localparam int BSW = BW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic [W-1:0]      input_word;
    logic              in_ready;
    logic [NP-1:0]     out_ready;
    logic [NP*SW-1:0]  to_output_buf;
    logic              pkt_done;
    logic              drop_err;

    logic              b_in_valid;
    logic [BW-1:0]     b_word;
    logic              b_in_ready;
    logic [BNP-1:0]    b_out_ready;
    logic [BNP*BSW-1:0] b_buf;
    logic              b_pkt_done;
    logic              b_drop_err;

    input_daemon_param #(.NUM_PORTS(NP), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .input_word(input_word),
        .in_ready(in_ready), .out_ready(out_ready), .to_output_buf(to_output_buf),
        .pkt_done(pkt_done), .drop_err(drop_err)
    );

    input_daemon_param #(.NUM_PORTS(BNP), .DATA_W(BW)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .input_word(b_word),
        .in_ready(b_in_ready), .out_ready(b_out_ready), .to_output_buf(b_buf),
        .pkt_done(b_pkt_done), .drop_err(b_drop_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents plus where we are in the current packet.
    bit            exp_v [NP];
    logic [W-1:0]  exp_d [NP];
    bit            exp_done;
    bit            exp_drop;
    int            words_left;   // 0 means the next word is a header
    bit            dropping;
    bit [NP-1:0]   tgt;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] hdr(input int tag, input int len, input int dst);
        return {tag[7:0], len[15:0], dst[7:0]};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            exp_v[p] = 1'b0;
            exp_d[p] = '0;
        end
        exp_done   = 1'b0;
        exp_drop   = 1'b0;
        words_left = 0;
        dropping   = 1'b0;
        tgt        = '0;
    endtask

    // One clock: drive, check readiness before the edge, update model, check after it.
    task automatic step(input bit v, input logic [W-1:0] w, input logic [NP-1:0] ordy,
                        output bit acc);
        bit [NP-1:0]      want;
        bit               rdy;
        int               d;
        int               len;
        logic [NP*SW-1:0] ef;
        @(negedge clk);
        in_valid   = v;
        input_word = w;
        out_ready  = ordy;
        #1;
        want = '0;
        d    = int'(w[7:0]);
        len  = int'(w[23:8]);
        if (words_left == 0) begin
            if (d >= 1 && d <= NP) want[d-1] = 1'b1;
`ifdef INPUT_DAEMON_BROADCAST_EN
            if (d == 255) want = '1;
`endif
        end else if (!dropping) begin
            want = tgt;
        end
        rdy = 1'b1;
        for (int p = 0; p < NP; p++) begin
            if (want[p] && exp_v[p] && !ordy[p]) rdy = 1'b0;
        end
        check("in_ready", in_ready, rdy);
        acc      = v && rdy;
        exp_done = 1'b0;
        exp_drop = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (exp_v[p] && ordy[p]) exp_v[p] = 1'b0;
        end
        if (acc) begin
            for (int p = 0; p < NP; p++) begin
                if (want[p]) begin
                    exp_v[p] = 1'b1;
                    exp_d[p] = w;
                end
            end
            if (words_left == 0) begin
                if (want != '0) begin
                    if (len == 0) exp_done = 1'b1;
                    else begin
                        words_left = len;
                        dropping   = 1'b0;
                        tgt        = want;
                    end
                end else begin
                    exp_drop   = 1'b1;
                    words_left = len;
                    dropping   = (len != 0);
                end
            end else begin
                words_left--;
                if (words_left == 0 && !dropping) exp_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) ef[p*SW +: SW] = {exp_v[p], exp_d[p]};
        check("to_output_buf", to_output_buf, ef);
        check("pkt_done", pkt_done, exp_done);
        check("drop_err", drop_err, exp_drop);
    endtask

    // Offer a word until the model accepts it; bubbles and backpressure are random.
    task automatic send_rand(input logic [W-1:0] w);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc) begin
            if (tries >= 6) step(1'b1, w, '1, acc);
            else if ($urandom_range(3) == 0) step(1'b0, w, NP'($urandom), acc);
            else step(1'b1, w, NP'($urandom), acc);
            tries++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = '1;
        b_in_valid  = 1'b0;
        b_out_ready = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check("rst_buf", to_output_buf, '0);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_drop_err", drop_err, 1'b0);
        check("rst_wide_buf", b_buf, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int r;
        int d;
        int len;
        rst         = 1'b1;
        in_valid    = 1'b0;
        input_word  = '0;
        out_ready   = '1;
        b_in_valid  = 1'b0;
        b_word      = '0;
        b_out_ready = '1;
        do_reset();

        // Basic forward to port 1.
        step(1'b1, hdr(3, 5, 1), '1, acc);
        step(1'b1, 32, '1, acc);
        step(1'b1, 10, '1, acc);
        step(1'b1, 7, '1, acc);
        step(1'b1, 128, '1, acc);
        step(1'b1, 200, '1, acc);
        step(1'b0, 0, '1, acc);

        // Backpressure on port 2 right after the header.
        step(1'b1, hdr(2, 3, 2), '1, acc);
        step(1'b1, 119, 4'b1101, acc);
        step(1'b1, 119, 4'b1101, acc);
        step(1'b1, 119, 4'b1101, acc);
        step(1'b1, 119, '1, acc);
        step(1'b1, 78, 4'b1101, acc);
        step(1'b1, 78, '1, acc);
        step(1'b1, 43, '1, acc);
        step(1'b0, 0, '1, acc);

        // Illegal destination dropped, then a zero-length packet.
        step(1'b1, hdr(1, 2, 9), '1, acc);
        step(1'b1, 5, '1, acc);
        step(1'b1, 6, '1, acc);
        step(1'b1, hdr(4, 0, 3), '1, acc);
        step(1'b1, hdr(4, 0, 0), '1, acc);
        step(1'b0, 0, '1, acc);

        // Broadcast (or drop when broadcast is not built in), with one slot stalled.
        step(1'b1, hdr(0, 1, 255), '1, acc);
        step(1'b1, 77, 4'b1110, acc);
        step(1'b1, 77, 4'b1110, acc);
        step(1'b1, 77, '1, acc);
        step(1'b0, 0, 4'b0000, acc);

        // Reset in the middle of a packet.
        step(1'b1, hdr(7, 5, 1), '1, acc);
        step(1'b1, 11, '1, acc);
        step(1'b1, 22, '1, acc);
        do_reset();
        step(1'b1, hdr(5, 0, 2), '1, acc);
        step(1'b0, 0, '1, acc);

        // Wide instance: 8 ports, 48-bit words, destination 8.
        @(negedge clk);
        b_in_valid = 1'b1;
        b_word     = {8'h5A, 32'd1, 8'd8};
        #1;
        check("wide_ready_hdr", b_in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("wide_slot8_hdr", b_buf[BNP*BSW-1 -: BSW], {1'b1, 8'h5A, 32'd1, 8'd8});
        @(negedge clk);
        b_word = 48'hABCDEF012345;
        #1;
        check("wide_ready_pay", b_in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("wide_slot8_pay", b_buf[BNP*BSW-1 -: BSW], {1'b1, 48'hABCDEF012345});
        check("wide_others", b_buf[(BNP-1)*BSW-1:0], '0);
        check("wide_pkt_done", b_pkt_done, 1'b1);
        @(negedge clk);
        b_in_valid = 1'b0;

        // Random packets.
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(9));
            if (r < 6) d = 1 + int'($urandom_range(NP - 1));
            else if (r < 8) d = 255;
            else if (r == 8) d = int'($urandom_range(254, 5));
            else d = 0;
            len = int'($urandom_range(4));
            send_rand(hdr(int'($urandom_range(255)), len, d));
            for (int k = 0; k < len; k++) send_rand($urandom);
        end
        step(1'b0, 0, '1, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
